// File: rtl/sseg_scan_driver_if.sv
// rtl/sseg_scan_driver_if.sv - value/mode input and display/busy output bundle for the scan driver
interface sseg_scan_driver_if;
  logic [15:0] DATA_IN;
  logic        MODE;
  logic [7:0]  CATHODES;
  logic [3:0]  ANODES;
  logic        BUSY;

  modport master (output DATA_IN, MODE, input CATHODES, ANODES, BUSY);
  modport slave  (input DATA_IN, MODE, output CATHODES, ANODES, BUSY);
endinterface

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - 4-digit common-anode scan driver, hex or decimal via sequential double-dabble
module sseg_scan_driver #(
  parameter int REFRESH_CNT = 100000,
  parameter int BLANK_CYC   = 2
) (
  input logic             CLK,
  input logic             RST_N,
  sseg_scan_driver_if.slave bus
);
  localparam int CW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  endfunction

  function automatic logic [19:0] dd_adjust(input logic [19:0] b);
    for (int k = 0; k < 5; k++)
      dd_adjust[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
  endfunction

  // Ten-thousands digit nonzero means the value cannot fit on four digits.
  function automatic logic [3:0][7:0] fmt_dec(input logic [19:0] b);
    if (|b[19:16]) begin
      fmt_dec = {4{8'hBF}};
    end else begin
      fmt_dec[3] = (b[15:12] == 4'd0) ? 8'hFF : seg(b[15:12]);
      fmt_dec[2] = (b[15:8]  == 8'd0) ? 8'hFF : seg(b[11:8]);
      fmt_dec[1] = (b[15:4]  == 12'd0) ? 8'hFF : seg(b[7:4]);
      fmt_dec[0] = seg(b[3:0]);
    end
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  state_t          state_q, state_d;
  logic [3:0]      iter_q, iter_d;
  logic [15:0]     snap_q, snap_d;
  logic [15:0]     sh_q, sh_d;
  logic [19:0]     bcd_q, bcd_d;
  logic [15:0]     last_data_q, last_data_d;
  logic            last_mode_q, last_mode_d;
  logic            force_q, force_d;
  logic [3:0][7:0] shown_q, shown_d;
  logic [3:0]      anodes_q, anodes_d;
  logic [7:0]      cathodes_q, cathodes_d;
  logic            busy_q, busy_d;

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    state_d     = state_q;
    iter_d      = iter_q;
    snap_d      = snap_q;
    sh_d        = sh_q;
    bcd_d       = bcd_q;
    last_data_d = last_data_q;
    last_mode_d = last_mode_q;
    force_d     = force_q;
    shown_d     = shown_q;
    busy_d      = busy_q;

    if (cnt_q == CW'(REFRESH_CNT - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (cnt_q < CW'(BLANK_CYC)) begin
      anodes_d   = 4'hF;
      cathodes_d = 8'hFF;
    end else begin
      anodes_d   = ~(4'b0001 << idx_q);
      cathodes_d = shown_q[idx_q];
    end

    case (state_q)
      IDLE: begin
        if (force_q || (bus.DATA_IN != last_data_q) || (bus.MODE != last_mode_q)) begin
          snap_d      = bus.DATA_IN;
          sh_d        = bus.DATA_IN;
          bcd_d       = '0;
          iter_d      = '0;
          last_data_d = bus.DATA_IN;
          last_mode_d = bus.MODE;
          force_d     = 1'b0;
          state_d     = bus.MODE ? CONV : DONE;
          busy_d      = bus.MODE;
        end
      end
      CONV: begin
        {bcd_d, sh_d} = {dd_adjust(bcd_q), sh_q} << 1;
        iter_d        = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = DONE;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        // last_mode_q is frozen outside IDLE, so it still names the captured mode.
        if (last_mode_q)
          shown_d = fmt_dec(bcd_q);
        else
          shown_d = {seg(snap_q[15:12]), seg(snap_q[11:8]), seg(snap_q[7:4]), seg(snap_q[3:0])};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      state_q     <= IDLE;
      iter_q      <= '0;
      snap_q      <= '0;
      sh_q        <= '0;
      bcd_q       <= '0;
      last_data_q <= '0;
      last_mode_q <= 1'b0;
      force_q     <= 1'b1;
      shown_q     <= {4{8'hFF}};
      anodes_q    <= 4'hF;
      cathodes_q  <= 8'hFF;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      iter_q      <= iter_d;
      snap_q      <= snap_d;
      sh_q        <= sh_d;
      bcd_q       <= bcd_d;
      last_data_q <= last_data_d;
      last_mode_q <= last_mode_d;
      force_q     <= force_d;
      shown_q     <= shown_d;
      anodes_q    <= anodes_d;
      cathodes_q  <= cathodes_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ANODES   = anodes_q;
  assign bus.CATHODES = cathodes_q;
  assign bus.BUSY     = busy_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - directed self-checking bench for sseg_scan_driver
module tb_sseg_scan_driver;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   tests = 0;
  int   failed = 0;

  sseg_scan_driver_if bus ();

  sseg_scan_driver #(.REFRESH_CNT(4), .BLANK_CYC(1)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_digit(input string tag, input int i, input logic [7:0] exp);
    logic [3:0] want;
    int k;
    want = ~(4'b0001 << i);
    k = 0;
    while (bus.ANODES !== want && k < 40) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 40) chk($sformatf("%s_d%0d_timeout", tag, i), {28'd0, bus.ANODES}, {28'd0, want});
    else         chk($sformatf("%s_d%0d", tag, i), {24'd0, bus.CATHODES}, {24'd0, exp});
  endtask

  task automatic check_all(input string tag, input logic [7:0] d3, input logic [7:0] d2,
                           input logic [7:0] d1, input logic [7:0] d0);
    check_digit(tag, 0, d0);
    check_digit(tag, 1, d1);
    check_digit(tag, 2, d2);
    check_digit(tag, 3, d3);
  endtask

  task automatic wait_conv(input string tag);
    int k;
    k = 0;
    while (bus.BUSY !== 1'b1 && k < 10) begin @(negedge CLK); k++; end
    chk({tag, "_busy_rise"}, {31'd0, bus.BUSY}, 32'd1);
    k = 0;
    while (bus.BUSY !== 1'b0 && k < 40) begin @(negedge CLK); k++; end
    chk({tag, "_busy_fall"}, {31'd0, bus.BUSY}, 32'd0);
    step(3);
  endtask

  logic [7:0] e1234 [4];
  logic [7:0] got   [4];

  initial begin
    int nb, nbusy, pulses, t_fall, k;
    logic prevb;

    e1234 = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    bus.DATA_IN = 16'h1A2F;
    bus.MODE    = 1'b0;
    RST_N       = 1'b0;

    step(3);
    chk("rst_anodes", {28'd0, bus.ANODES}, 32'hF);
    chk("rst_cathodes", {24'd0, bus.CATHODES}, 32'hFF);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);

    RST_N = 1'b1;
    step(4);
    check_all("hex1A2F", 8'hF9, 8'h88, 8'hA4, 8'h8E);
    nb = 0;
    repeat (16) begin
      step(1);
      if (bus.ANODES == 4'hF) nb++;
    end
    chk("hex_blank_cnt", nb, 32'd4);

    k = 0;
    while (bus.ANODES == 4'hF && k < 20) begin step(1); k++; end
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_anodes", {28'd0, bus.ANODES}, 32'hF);
    chk("midrst_cathodes", {24'd0, bus.CATHODES}, 32'hFF);
    @(negedge CLK);
    RST_N = 1'b1;

    bus.DATA_IN = 16'd305;
    bus.MODE    = 1'b1;
    nbusy = 0;
    repeat (30) begin
      step(1);
      if (bus.BUSY) nbusy++;
    end
    chk("d305_busy_cycles", nbusy, 32'd16);
    check_all("d305", 8'hFF, 8'hB0, 8'hC0, 8'h92);

    bus.DATA_IN = 16'd0;
    wait_conv("d0");
    check_all("d0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);

    bus.DATA_IN = 16'd10000;
    wait_conv("d10000");
    check_all("d10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

    bus.DATA_IN = 16'hFFFF;
    wait_conv("dFFFF");
    check_all("dFFFF", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

    // 1234 captured, 42 arrives mid-conversion; 1234 must still be shown in full.
    bus.DATA_IN = 16'd1234;
    pulses = 0;
    t_fall = -1;
    prevb  = 1'b0;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    for (int c = 0; c < 80; c++) begin
      step(1);
      if (c == 4) bus.DATA_IN = 16'd42;
      if (bus.BUSY && !prevb) pulses++;
      if (!bus.BUSY && prevb && t_fall < 0) t_fall = c;
      prevb = bus.BUSY;
      if (t_fall >= 0 && c >= t_fall + 2 && c < t_fall + 18)
        for (int i = 0; i < 4; i++)
          if (bus.ANODES == ~(4'b0001 << i) && (got[i] == 8'h00 || got[i] == e1234[i]))
            got[i] = bus.CATHODES;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("upd_first_d%0d", i), {24'd0, got[i]}, {24'd0, e1234[i]});
    chk("upd_busy_pulses", pulses, 32'd2);
    check_all("upd42", 8'hFF, 8'hFF, 8'h99, 8'hA4);

    bus.DATA_IN = 16'h0010;
    bus.MODE    = 1'b0;
    step(4);
    check_all("mode_hex", 8'hC0, 8'hC0, 8'hF9, 8'hC0);
    bus.MODE = 1'b1;
    wait_conv("mode_dec");
    check_all("mode_dec", 8'hFF, 8'hFF, 8'hF9, 8'h82);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
